dmem_ctrl: RTL and testbench

Parametrised multi-cycle data-memory controller for the MEM stage. Serves one load or store at a time from the pipeline's ALU-computed byte address, models a fixed memory latency, and stalls the pipeline with `freeze_out` while an access is in flight. Adds address-range and alignment checking and registered read data over the single-cycle memory it replaces.

---
 rtl/dmem_ctrl_pkg.sv | 16 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// FSM state encoding, the enable constant and the default register length.
package dmem_ctrl_pkg;

  // Register length used as the default data width
  localparam int REG_LEN = 32;

  // Generic single-bit enable value
  localparam logic ENABLE = 1'b1;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : dmem_ctrl_pkg

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage for the data-memory controller.
// Synchronous write with per-byte lane mask, asynchronous read.
// Holds no control logic; contents are intentionally never reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH),
  parameter int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     wben,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Lane-masked synchronous write of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && wben[i]) begin
        mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule : dmem_array

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller for the MEM stage.
// Serves one load or store at a time, models a fixed access latency,
// stalls the pipeline via freeze_out, and flags out-of-range or
// misaligned accesses through addr_err_out.
// Optional feature macro: DMEM_BYTE_WRITE_EN (adds byte_en_in and
// lane-masked stores; without it stores write the full word).
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_W    = REG_LEN,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic [DATA_W-1:0]   alu_result_in,
  input  logic [DATA_W-1:0]   data_in,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] byte_en_in,
`endif
  output logic [DATA_W-1:0]   data_out,
  output logic                ready_out,
  output logic                freeze_out,
  output logic                addr_err_out
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);

  localparam logic [DATA_W-1:0] BASE_W    = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] DEPTH_W   = DATA_W'(DEPTH);
  localparam logic [DATA_W-1:0] LANE_MASK = DATA_W'(NB - 1);
  localparam logic [CW-1:0]     CNT_INIT  = CW'(LATENCY - 1);

  logic [1:0]        state_r;
  logic [CW-1:0]     cnt_r;
  logic              op_wr_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [NB-1:0]     ben_r;
  logic [DATA_W-1:0] data_r;
  logic              ready_r;
  logic              addr_err_r;

  logic [NB-1:0]     ben_s;
  logic [DATA_W-1:0] offset_s;
  logic [AW-1:0]     index_s;
  logic              legal_s;
  logic              last_s;
  logic              we_s;
  logic              freeze_s;
  logic [DATA_W-1:0] rdata_s;

`ifdef DMEM_BYTE_WRITE_EN
  assign ben_s = byte_en_in;
`else
  assign ben_s = {NB{1'b1}};
`endif

  assign offset_s = addr_r - BASE_W;
  assign index_s  = offset_s[LSB +: AW];

  // Legality of the latched address: in range and word aligned
  always_comb begin
    legal_s = 1'b0;
    if ((addr_r >= BASE_W) &&
        ((offset_s >> LSB) < DEPTH_W) &&
        ((addr_r & LANE_MASK) == {DATA_W{1'b0}})) begin
      legal_s = 1'b1;
    end else begin
      legal_s = 1'b0;
    end
  end

  // Final BUSY cycle detection and store commit enable
  always_comb begin
    last_s = 1'b0;
    we_s   = 1'b0;
    if ((state_r == ST_BUSY) && (cnt_r == {CW{1'b0}})) begin
      last_s = 1'b1;
      we_s   = op_wr_r && legal_s;
    end else begin
      last_s = 1'b0;
      we_s   = 1'b0;
    end
  end

  // Pipeline stall: request cycle in IDLE and every BUSY cycle
  always_comb begin
    freeze_s = 1'b0;
    if (state_r == ST_BUSY) begin
      freeze_s = 1'b1;
    end else if ((state_r == ST_IDLE) && (mem_read_in || mem_write_in)) begin
      freeze_s = 1'b1;
    end else begin
      freeze_s = 1'b0;
    end
  end

  // Access FSM, request latching and registered completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      op_wr_r    <= 1'b0;
      addr_r     <= {DATA_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      ben_r      <= {NB{1'b0}};
      data_r     <= {DATA_W{1'b0}};
      ready_r    <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      ready_r    <= 1'b0;
      addr_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_read_in || mem_write_in) begin
            // A simultaneous read and write request is served as a store
            op_wr_r <= mem_write_in;
            addr_r  <= alu_result_in;
            wdata_r <= data_in;
            ben_r   <= ben_s;
            cnt_r   <= CNT_INIT;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (last_s) begin
            // Completion outputs are registered so they are valid in DONE
            state_r    <= ST_DONE;
            ready_r    <= ENABLE;
            addr_err_r <= !legal_s;
            if (!op_wr_r) begin
              data_r <= legal_s ? rdata_s : {DATA_W{1'b0}};
            end else begin
              data_r <= data_r;
            end
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          // Requests seen here belong to the instruction just served
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW),
    .NB     (NB)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .addr  (index_s),
    .wdata (wdata_r),
    .wben  (ben_r),
    .rdata (rdata_s)
  );

  assign data_out     = data_r;
  assign ready_out    = ready_r;
  assign freeze_out   = freeze_s;
  assign addr_err_out = addr_err_r;

endmodule : dmem_ctrl

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with default parameters.
// Expected completions are queued when a request is driven and
// compared against the DUT when ready_out pulses.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] alu_result_in;
  logic [31:0] data_in;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  byte_en_in;
`endif
  logic [31:0] data_out;
  logic        ready_out;
  logic        freeze_out;
  logic        addr_err_out;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ben;
    bit          exp_err;
  } txn_t;

  txn_t        sb_q [$];
  logic [31:0] model_mem [int];
  logic [31:0] last_load;
  int          n_checks;
  int          n_fail;

  dmem_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .alu_result_in (alu_result_in),
    .data_in       (data_in),
`ifdef DMEM_BYTE_WRITE_EN
    .byte_en_in    (byte_en_in),
`endif
    .data_out      (data_out),
    .ready_out     (ready_out),
    .freeze_out    (freeze_out),
    .addr_err_out  (addr_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drop_req();
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  task automatic drive_req(input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] ben,
                           input bit exp_err);
    txn_t t;
    mem_read_in   = !wr;
    mem_write_in  = wr;
    alu_result_in = addr;
    data_in       = data;
`ifdef DMEM_BYTE_WRITE_EN
    byte_en_in    = ben;
`endif
    t.is_wr   = wr;
    t.addr    = addr;
    t.data    = data;
    t.ben     = ben;
    t.exp_err = exp_err;
    sb_q.push_back(t);
  endtask

  // One access from request to completion; called right after a posedge.
  task automatic access(input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] ben,
                        input bit exp_err, input bit hold);
    txn_t        t;
    logic [31:0] exp;
    int          frz;
    int          rdy_cyc;
    bit          got;
    drive_req(wr, addr, data, ben, exp_err);
    frz = 0;
    rdy_cyc = -1;
    got = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (!got) begin
        @(negedge clk);
        if (freeze_out) frz++;
        if (ready_out) begin
          got = 1'b1;
          rdy_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (!hold) drop_req();
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL timeout addr=%0d: ready_out never seen", addr);
      void'(sb_q.pop_front());
    end else begin
      n_checks++;
      if (rdy_cyc !== 3) begin
        n_fail++;
        $display("FAIL ready_cycle addr=%0d: got %0d want 3", addr, rdy_cyc);
      end
      n_checks++;
      if (frz !== 3) begin
        n_fail++;
        $display("FAIL freeze_cycles addr=%0d: got %0d want 3", addr, frz);
      end
    end
  endtask

  // Compare completion outputs against the queue head at the DONE cycle
  always @(negedge clk) begin
    txn_t        t;
    logic [31:0] exp;
    if (rst && ready_out) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ready: ready_out with empty scoreboard");
      end else begin
        t = sb_q.pop_front();
        n_checks++;
        if (addr_err_out !== t.exp_err) begin
          n_fail++;
          $display("FAIL addr_err addr=%0d: got %b want %b", t.addr, addr_err_out, t.exp_err);
        end
        if (t.is_wr) begin
          if (!t.exp_err) begin
            exp = model_mem.exists(int'(t.addr)) ? model_mem[int'(t.addr)] : 32'h0000_0000;
            for (int i = 0; i < 4; i++) begin
`ifdef DMEM_BYTE_WRITE_EN
              if (t.ben[i]) exp[i*8 +: 8] = t.data[i*8 +: 8];
`else
              exp[i*8 +: 8] = t.data[i*8 +: 8];
`endif
            end
            model_mem[int'(t.addr)] = exp;
          end
          n_checks++;
          if (data_out !== last_load) begin
            n_fail++;
            $display("FAIL store_keeps_data addr=%0d: got %h want %h", t.addr, data_out, last_load);
          end
        end else begin
          if (t.exp_err) exp = 32'h0000_0000;
          else if (model_mem.exists(int'(t.addr))) exp = model_mem[int'(t.addr)];
          else exp = 32'hxxxx_xxxx;
          last_load = exp;
          n_checks++;
          if (data_out !== exp) begin
            n_fail++;
            $display("FAIL load_data addr=%0d: got %h want %h", t.addr, data_out, exp);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    drop_req();
    alu_result_in = 32'd0;
    data_in = 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
    byte_en_in = 4'hF;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data_out, ready_out, freeze_out, addr_err_out} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h rdy=%b frz=%b err=%b want all 0",
               data_out, ready_out, freeze_out, addr_err_out);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    access(1'b1, 32'd1024, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    access(1'b0, 32'd1024, 32'h0000_0000, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    access(1'b1, 32'd1276, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    access(1'b0, 32'd1020, 32'h0000_0000, 4'hF, 1'b1, 1'b0);
    access(1'b0, 32'd1026, 32'h0000_0000, 4'hF, 1'b1, 1'b0);
    access(1'b1, 32'd1280, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
    access(1'b0, 32'd1276, 32'h0000_0000, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic test_last_word();
    access(1'b1, 32'd1276, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
    access(1'b0, 32'd1276, 32'h0000_0000, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    access(1'b0, 32'd1024, 32'h0000_0000, 4'hF, 1'b0, 1'b1);
    access(1'b0, 32'd1276, 32'h0000_0000, 4'hF, 1'b0, 1'b1);
    drop_req();
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (ready_out !== 1'b0 || freeze_out !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle: got rdy=%b frz=%b want 0 0", ready_out, freeze_out);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_access();
    access(1'b1, 32'd1028, 32'h1111_1111, 4'hF, 1'b0, 1'b0);
    drive_req(1'b1, 32'd1028, 32'h2222_2222, 4'hF, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    drop_req();
    @(negedge clk);
    n_checks++;
    if (freeze_out !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_freeze: got %b want 1", freeze_out);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({data_out, ready_out, freeze_out, addr_err_out} !== 35'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got data=%h rdy=%b frz=%b err=%b want all 0",
               data_out, ready_out, freeze_out, addr_err_out);
    end
    sb_q.delete();
    last_load = 32'h0000_0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 32'd1028, 32'h0000_0000, 4'hF, 1'b0, 1'b0);
  endtask

`ifdef DMEM_BYTE_WRITE_EN
  task automatic test_byte_write();
    access(1'b1, 32'd1032, 32'hAABB_CCDD, 4'hF, 1'b0, 1'b0);
    access(1'b1, 32'd1032, 32'h0000_0011, 4'h1, 1'b0, 1'b0);
    access(1'b1, 32'd1032, 32'h9999_9999, 4'h0, 1'b0, 1'b0);
    access(1'b0, 32'd1032, 32'h0000_0000, 4'hF, 1'b0, 1'b0);
    n_checks++;
    if (data_out !== 32'hAABB_CC11) begin
      n_fail++;
      $display("FAIL byte_write: got %h want aabbcc11", data_out);
    end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_load = 32'h0000_0000;
    test_reset();
    test_store_load();
    test_illegal();
    test_last_word();
    test_back_to_back();
    test_reset_mid_access();
`ifdef DMEM_BYTE_WRITE_EN
    test_byte_write();
`endif
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_ctrl
